// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the instruction-ROM arbiter.
package imem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_LD = 1'b1
  } req_id_t;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_OUT_WIDTH  = 32;
  localparam int BYTES_PER_WORD = DEF_OUT_WIDTH / DEF_DATA_WIDTH;
  localparam int BYTE_CNT_WIDTH = 2;
  localparam logic [BYTE_CNT_WIDTH-1:0] LAST_BYTE = BYTE_CNT_WIDTH'(BYTES_PER_WORD - 1);

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant, registered last-grant bit.
// A lone request always wins; on contention the requester not served last wins.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update_en,
  output logic [1:0] grant
);

  // 1 means requester 1 was served last; reset value gives requester 0 priority
  logic last_r;

  // Grant selection from the current requests and the last-served bit
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_r ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Last-served pointer, moved only when a grant is actually taken
  always_ff @(posedge clk) begin
    if (rst) begin
      last_r <= 1'b1;
    end else if (update_en) begin
      last_r <= grant[1];
    end else begin
      last_r <= last_r;
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// Shares the byte-wide synchronous-read boot ROM between instruction fetch (IF)
// and ROM loads (LD). Each accepted request issues four byte reads, assembles
// them little-endian and pulses the word back to the requester that asked.
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 8,
  parameter int OUT_WIDTH      = 32,
  parameter int MEM_ADDR_WIDTH = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      if_req_valid,
  input  logic [ADDRESS_WIDTH-1:0]  if_req_addr,
  output logic                      if_req_ready,
  output logic                      if_resp_valid,
  output logic [OUT_WIDTH-1:0]      if_resp_data,
  input  logic                      ld_req_valid,
  input  logic [ADDRESS_WIDTH-1:0]  ld_req_addr,
  output logic                      ld_req_ready,
  output logic                      ld_resp_valid,
  output logic [OUT_WIDTH-1:0]      ld_resp_data,
  output logic                      rom_rd_en,
  output logic [MEM_ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0]     rom_rdata
);

  state_t                    state_r, state_next_s;
  req_id_t                   id_r;
  logic [BYTE_CNT_WIDTH-1:0] cnt_r;
  logic                      cap_valid_r;
  logic [BYTE_CNT_WIDTH-1:0] cap_lane_r;
  logic [OUT_WIDTH-1:0]      asm_r, asm_next_s;
  logic [1:0]                grant_s;
  logic                      accept_s;
  logic                      rd_en_next_s;
  logic                      if_fire_s, ld_fire_s;
  logic [MEM_ADDR_WIDTH-1:0] sel_addr_s;
  logic                      rom_rd_en_r;
  logic [MEM_ADDR_WIDTH-1:0] rom_addr_r;
  logic                      if_resp_valid_r, ld_resp_valid_r;
  logic [OUT_WIDTH-1:0]      if_resp_data_r, ld_resp_data_r;
  logic                      unused_addr_bits_s;

  // Only the ROM offset matters; the boot-region upper bits are dropped
  assign unused_addr_bits_s = ^{if_req_addr[ADDRESS_WIDTH-1:MEM_ADDR_WIDTH],
                                ld_req_addr[ADDRESS_WIDTH-1:MEM_ADDR_WIDTH]};

  rr_arbiter2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       ({ld_req_valid, if_req_valid}),
    .update_en (accept_s),
    .grant     (grant_s)
  );

  assign accept_s   = (state_r == IDLE) && (grant_s != 2'b00);
  assign sel_addr_s = grant_s[1] ? ld_req_addr[MEM_ADDR_WIDTH-1:0]
                                 : if_req_addr[MEM_ADDR_WIDTH-1:0];

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    state_next_s = accept_s ? ISSUE : IDLE;
      ISSUE:   state_next_s = (cnt_r == LAST_BYTE) ? DRAIN : ISSUE;
      DRAIN:   state_next_s = RESP;
      RESP:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // FSM outputs: handshake readies plus next values for the registered outputs
  always_comb begin
    if_req_ready = (state_r == IDLE) && grant_s[0];
    ld_req_ready = (state_r == IDLE) && grant_s[1];
    rd_en_next_s = (state_next_s == ISSUE);
    if_fire_s    = (state_r == DRAIN) && (id_r == REQ_IF);
    ld_fire_s    = (state_r == DRAIN) && (id_r == REQ_LD);
  end

  // Drop each returning byte into the lane of the strobe that fetched it
  always_comb begin
    asm_next_s = asm_r;
    if (cap_valid_r) begin
      asm_next_s[int'(cap_lane_r) * DATA_WIDTH +: DATA_WIDTH] = rom_rdata;
    end else begin
      asm_next_s = asm_r;
    end
  end

  // Request latches, byte counter, ROM strobe/address and capture pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      id_r        <= REQ_IF;
      cnt_r       <= '0;
      rom_rd_en_r <= 1'b0;
      rom_addr_r  <= '0;
      cap_valid_r <= 1'b0;
      cap_lane_r  <= '0;
      asm_r       <= '0;
    end else begin
      rom_rd_en_r <= rd_en_next_s;
      cap_valid_r <= rom_rd_en_r;
      cap_lane_r  <= cnt_r;
      asm_r       <= asm_next_s;
      if (accept_s) begin
        id_r       <= grant_s[1] ? REQ_LD : REQ_IF;
        cnt_r      <= '0;
        rom_addr_r <= sel_addr_s;
      end else if (state_r == ISSUE) begin
        cnt_r <= cnt_r + BYTE_CNT_WIDTH'(1);
        // Offset add wraps naturally at the ROM size
        if (cnt_r != LAST_BYTE) begin
          rom_addr_r <= rom_addr_r + MEM_ADDR_WIDTH'(1);
        end else begin
          rom_addr_r <= rom_addr_r;
        end
      end else begin
        cnt_r      <= cnt_r;
        rom_addr_r <= rom_addr_r;
      end
    end
  end

  // Per-requester response registers; data holds until that requester's next word
  always_ff @(posedge clk) begin
    if (rst) begin
      if_resp_valid_r <= 1'b0;
      ld_resp_valid_r <= 1'b0;
      if_resp_data_r  <= '0;
      ld_resp_data_r  <= '0;
    end else begin
      if_resp_valid_r <= if_fire_s;
      ld_resp_valid_r <= ld_fire_s;
      if (if_fire_s) begin
        if_resp_data_r <= asm_next_s;
      end else begin
        if_resp_data_r <= if_resp_data_r;
      end
      if (ld_fire_s) begin
        ld_resp_data_r <= asm_next_s;
      end else begin
        ld_resp_data_r <= ld_resp_data_r;
      end
    end
  end

  assign rom_rd_en     = rom_rd_en_r;
  assign rom_addr      = rom_addr_r;
  assign if_resp_valid = if_resp_valid_r;
  assign if_resp_data  = if_resp_data_r;
  assign ld_resp_valid = ld_resp_valid_r;
  assign ld_resp_data  = ld_resp_data_r;

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: a ROM model, a transaction-level reference model
// checked every cycle, and directed scenarios with literal expectations.
module tb_imem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req_valid, ld_req_valid;
  logic [31:0] if_req_addr, ld_req_addr;
  logic        if_req_ready, ld_req_ready;
  logic        if_resp_valid, ld_resp_valid;
  logic [31:0] if_resp_data, ld_resp_data;
  logic        rom_rd_en;
  logic [11:0] rom_addr;
  logic [7:0]  rom_rdata;

  logic [7:0]  rom [4096];
  int          n_cmp;
  int          n_bad;

  imem_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .if_req_valid  (if_req_valid),
    .if_req_addr   (if_req_addr),
    .if_req_ready  (if_req_ready),
    .if_resp_valid (if_resp_valid),
    .if_resp_data  (if_resp_data),
    .ld_req_valid  (ld_req_valid),
    .ld_req_addr   (ld_req_addr),
    .ld_req_ready  (ld_req_ready),
    .ld_resp_valid (ld_resp_valid),
    .ld_resp_data  (ld_resp_data),
    .rom_rd_en     (rom_rd_en),
    .rom_addr      (rom_addr),
    .rom_rdata     (rom_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read ROM: data appears the cycle after the strobe
  initial rom_rdata = 8'h00;
  always @(posedge clk) begin
    if (rom_rd_en) rom_rdata <= rom[rom_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [11:0] b);
    logic [11:0] a0, a1, a2, a3;
    a0 = b;
    a1 = b + 12'd1;
    a2 = b + 12'd2;
    a3 = b + 12'd3;
    return {rom[a3], rom[a2], rom[a1], rom[a0]};
  endfunction

  // Reference model: a request taken at cycle T strobes base+0..3 in T+1..T+4
  // and answers in T+6; it is idle again at T+7.
  bit          m_on;
  int          m_phase;
  bit          m_last_ld;
  bit          m_id_ld;
  logic [11:0] m_base;
  logic [31:0] e_if_data, e_ld_data;

  initial begin
    m_on = 1'b0;
    m_phase = 0;
    m_last_ld = 1'b1;
    m_id_ld = 1'b0;
    m_base = 12'd0;
    e_if_data = 32'd0;
    e_ld_data = 32'd0;
  end

  always @(negedge clk) begin
    bit g_if, g_ld;
    logic [11:0] ea;
    g_if = 1'b0;
    g_ld = 1'b0;
    if (m_phase == 0) begin
      if (if_req_valid && ld_req_valid) begin
        g_if = m_last_ld;
        g_ld = !m_last_ld;
      end else begin
        g_if = if_req_valid;
        g_ld = ld_req_valid;
      end
    end
    if (m_on) begin
      if (m_phase == 6) begin
        if (m_id_ld) e_ld_data = word_at(m_base);
        else         e_if_data = word_at(m_base);
      end
      ea = m_base + 12'(m_phase - 1);
      chk("model_if_ready", {31'd0, if_req_ready}, {31'd0, g_if});
      chk("model_ld_ready", {31'd0, ld_req_ready}, {31'd0, g_ld});
      chk("model_rd_en", {31'd0, rom_rd_en}, {31'd0, (m_phase >= 1 && m_phase <= 4)});
      if (m_phase >= 1 && m_phase <= 4) chk("model_rom_addr", {20'd0, rom_addr}, {20'd0, ea});
      chk("model_if_resp_valid", {31'd0, if_resp_valid}, {31'd0, (m_phase == 6 && !m_id_ld)});
      chk("model_ld_resp_valid", {31'd0, ld_resp_valid}, {31'd0, (m_phase == 6 && m_id_ld)});
      chk("model_if_resp_data", if_resp_data, e_if_data);
      chk("model_ld_resp_data", ld_resp_data, e_ld_data);
    end
    if (rst) begin
      m_on = 1'b1;
      m_phase = 0;
      m_last_ld = 1'b1;
      e_if_data = 32'd0;
      e_ld_data = 32'd0;
    end else if (m_on) begin
      if (m_phase == 0) begin
        if (g_if || g_ld) begin
          m_phase = 1;
          m_id_ld = g_ld;
          m_base = g_ld ? ld_req_addr[11:0] : if_req_addr[11:0];
          m_last_ld = g_ld;
        end
      end else if (m_phase == 6) begin
        m_phase = 0;
      end else begin
        m_phase++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One lone request: ready in T, addresses a0..a0+3 in T+1..T+4, word at T+6
  task automatic run_single(input bit is_ld, input logic [31:0] addr,
                            input logic [11:0] a0, input logic [31:0] exp_word,
                            input string tag);
    int got;
    logic [31:0] data;
    logic [11:0] ea;
    got = 0;
    data = 32'd0;
    if (is_ld) begin ld_req_valid = 1'b1; ld_req_addr = addr; end
    else       begin if_req_valid = 1'b1; if_req_addr = addr; end
    #1;
    chk({tag, "_ready"}, {31'd0, (is_ld ? ld_req_ready : if_req_ready)}, 32'd1);
    step(1);
    if_req_valid = 1'b0;
    ld_req_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (k <= 4) begin
        ea = a0 + 12'(k - 1);
        chk({tag, "_strobe"}, {31'd0, rom_rd_en}, 32'd1);
        chk({tag, "_addr"}, {20'd0, rom_addr}, {20'd0, ea});
      end
      chk({tag, "_other_resp"}, {31'd0, (is_ld ? if_resp_valid : ld_resp_valid)}, 32'd0);
      if (is_ld ? ld_resp_valid : if_resp_valid) begin
        got = k;
        data = is_ld ? ld_resp_data : if_resp_data;
      end
      step(1);
    end
    chk({tag, "_latency"}, got, 32'd6);
    chk({tag, "_word"}, data, exp_word);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int if1, if2, ld1, nif, nld;
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 4096; i++) rom[i] = 8'(i * 37 + 5);
    rom[12'h000] = 8'h13; rom[12'h001] = 8'h00; rom[12'h002] = 8'h00; rom[12'h003] = 8'h00;
    rom[12'hFFE] = 8'hAA; rom[12'hFFF] = 8'hBB;
    rom[12'h101] = 8'h11; rom[12'h102] = 8'h22; rom[12'h103] = 8'h33; rom[12'h104] = 8'h44;

    rst = 1'b1;
    if_req_valid = 1'b0; ld_req_valid = 1'b0;
    if_req_addr = 32'd0; ld_req_addr = 32'd0;
    step(2);
    chk("rst_rd_en", {31'd0, rom_rd_en}, 32'd0);
    chk("rst_rom_addr", {20'd0, rom_addr}, 32'd0);
    chk("rst_if_valid", {31'd0, if_resp_valid}, 32'd0);
    chk("rst_ld_valid", {31'd0, ld_resp_valid}, 32'd0);
    chk("rst_if_data", if_resp_data, 32'd0);
    chk("rst_ld_data", ld_resp_data, 32'd0);
    rst = 1'b0;
    step(1);

    run_single(1'b0, 32'hBFC00000, 12'h000, 32'h00000013, "single_if");
    run_single(1'b1, 32'h00000FFE, 12'hFFE, 32'h0013BBAA, "wrap_ld");
    run_single(1'b0, 32'h00000101, 12'h101, 32'h44332211, "misaligned_if");

    // Reset in T+3 of an LD transaction
    ld_req_valid = 1'b1; ld_req_addr = 32'h00000200;
    #1;
    chk("rst_mid_ld_ready", {31'd0, ld_req_ready}, 32'd1);
    step(1);
    ld_req_valid = 1'b0;
    step(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    #1;
    chk("rst_mid_rd_en", {31'd0, rom_rd_en}, 32'd0);
    chk("rst_mid_ld_data", ld_resp_data, 32'd0);
    chk("rst_mid_if_data", if_resp_data, 32'd0);
    step(1);
    for (int k = 0; k < 8; k++) begin
      chk("rst_mid_no_resp", {31'd0, ld_resp_valid}, 32'd0);
      step(1);
    end

    // Both requesters hold valid: IF, LD, IF at T, T+7, T+14
    if_req_valid = 1'b1; if_req_addr = 32'hBFC00010;
    ld_req_valid = 1'b1; ld_req_addr = 32'h00000020;
    #1;
    chk("both_if_ready_T", {31'd0, if_req_ready}, 32'd1);
    chk("both_ld_ready_T", {31'd0, ld_req_ready}, 32'd0);
    if1 = 0; if2 = 0; ld1 = 0; nif = 0; nld = 0;
    for (int k = 0; k <= 21; k++) begin
      if (k == 15) begin if_req_valid = 1'b0; ld_req_valid = 1'b0; end
      if (k == 7)  chk("both_ld_ready_T7", {31'd0, ld_req_ready}, 32'd1);
      if (k == 14) chk("both_if_ready_T14", {31'd0, if_req_ready}, 32'd1);
      if (if_resp_valid) begin
        nif++;
        if (nif == 1) if1 = k; else if2 = k;
      end
      if (ld_resp_valid) begin
        nld++;
        ld1 = k;
      end
      step(1);
    end
    chk("both_if_first", if1, 32'd6);
    chk("both_ld_resp", ld1, 32'd13);
    chk("both_if_second", if2, 32'd20);
    chk("both_if_count", nif, 32'd2);
    chk("both_ld_count", nld, 32'd1);
    step(3);

    // LD raised at T+2 while IF is being served: held, taken at T+7
    if_req_valid = 1'b1; if_req_addr = 32'h00000040;
    step(1);
    if_req_valid = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      if (k == 2) begin ld_req_valid = 1'b1; ld_req_addr = 32'h00000060; end
      if (k >= 3 && k <= 6) chk("busy_ld_not_ready", {31'd0, ld_req_ready}, 32'd0);
      if (k >= 5 && k <= 7) chk("busy_no_strobe", {31'd0, rom_rd_en}, 32'd0);
      if (k == 7) chk("busy_ld_ready_T7", {31'd0, ld_req_ready}, 32'd1);
      if (k == 8) ld_req_valid = 1'b0;
      step(1);
    end
    step(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
